// File: rtl/neuron_pkg.sv
// Shared definitions for the neuron layer.
//   state_e  : controller states (IDLE / MAC / OUT)
//   CFG_*    : cfg_sel encodings
//   sat_add  : signed add clamped to a w-bit two's-complement range
package neuron_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

  localparam logic [1:0] CFG_W   = 2'd0;
  localparam logic [1:0] CFG_B   = 2'd1;
  localparam logic [1:0] CFG_T   = 2'd2;
  localparam logic [1:0] CFG_RSV = 2'd3;

  // Operands are carried at 64 bits so the raw sum never wraps; the caller
  // truncates the clamped result back to w bits.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int w);
    logic signed [63:0] s, hi, lo;
    s  = a + b;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (s > hi)      return hi;
    else if (s < lo) return lo;
    else             return s;
  endfunction

endpackage

// File: rtl/neuron_mac.sv
// Shared multiply-accumulate datapath, one term per issue.
//   clk, rst     : clock, async active-high reset
//   issue_i      : a term (x_i, w_i) is presented this cycle
//   x_i, w_i     : unsigned input element, signed weight
//   load_i       : overwrite accumulator with load_val_i (neuron start)
//   prod_vld_o   : product register holds a term that is summed this cycle
//   sum_o        : saturated acc + product (combinational)
// The product is registered, so a term issued in cycle n lands in the
// accumulator at the end of cycle n+1.
module neuron_mac
  import neuron_pkg::*;
#(
  parameter int XW   = 4,
  parameter int WW   = 4,
  parameter int ACCW = 12
)(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue_i,
  input  logic [XW-1:0]          x_i,
  input  logic signed [WW-1:0]   w_i,
  input  logic                   load_i,
  input  logic signed [ACCW-1:0] load_val_i,
  output logic                   prod_vld_o,
  output logic signed [ACCW-1:0] sum_o
);

  localparam int PW = XW + WW + 1;

  logic signed [PW-1:0]   prod_d, prod_q;
  logic signed [ACCW-1:0] acc_d, acc_q;
  logic                   vld_q;

  // x is zero-extended (extra 0 sign bit), w sign-extended; PW bits hold the
  // full product exactly.
  assign prod_d = PW'($signed({1'b0, x_i})) * PW'(w_i);

  assign sum_o      = ACCW'(sat_add(64'(acc_q), 64'(prod_q), ACCW));
  assign prod_vld_o = vld_q;

  // A load coincides with the last sum of the previous neuron; that sum is
  // consumed by the caller this cycle, so the load may overwrite it.
  always_comb begin
    acc_d = acc_q;
    if (load_i)     acc_d = load_val_i;
    else if (vld_q) acc_d = sum_o;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q <= '0;
      vld_q  <= 1'b0;
      acc_q  <= '0;
    end else begin
      vld_q <= issue_i;
      if (issue_i) prod_q <= prod_d;
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/neuron_layer.sv
// Layer of N_OUT neurons sharing one MAC, threshold or LIF firing.
//   clk, rst                 : clock, async active-high reset
//   cfg_we/sel/addr/data     : weight/bias/threshold writes (IDLE only)
//   cfg_busy                 : controller not in IDLE
//   mode                     : 0 threshold, 1 LIF (latched on accept)
//   clear                    : zero membranes (IDLE only)
//   in_valid/in_ready, x_in  : input vector handshake
//   out_valid/out_ready,y_out: fire-bit handshake
// Output appears N_IN*N_OUT+1 cycles after accept: N_IN*N_OUT issue cycles
// plus one for the registered product.
module neuron_layer
  import neuron_pkg::*;
#(
  parameter int N_IN  = 2,
  parameter int N_OUT = 2,
  parameter int XW    = 4,
  parameter int WW    = 4,
  parameter int ACCW  = 12,
  parameter int LEAK  = 2,
  localparam int NT   = N_IN * N_OUT,
  localparam int AW   = (NT > 1) ? $clog2(NT) : 1
)(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_we,
  input  logic [1:0]           cfg_sel,
  input  logic [AW-1:0]        cfg_addr,
  input  logic [ACCW-1:0]      cfg_data,
  output logic                 cfg_busy,
  input  logic                 mode,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_IN*XW-1:0]   x_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N_OUT-1:0]     y_out
);

  localparam int IW = (N_IN  > 1) ? $clog2(N_IN)  : 1;
  localparam int JW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  state_e state_q, state_d;

  logic                   accept, issue, fin, fin_last, prod_vld, fire;
  logic [N_IN-1:0][XW-1:0] x_q;
  logic                   mode_q;
  logic                   iss_q;
  logic [IW-1:0]          ii_q, ti_q;
  logic [JW-1:0]          jj_q, tj_q, jn;
  logic [AW-1:0]          wk;

  logic signed [WW-1:0]   w_q [NT];
  logic signed [ACCW-1:0] b_q [N_OUT];
  logic signed [ACCW-1:0] t_q [N_OUT];
  logic signed [ACCW-1:0] v_q [N_OUT];
  logic [N_OUT-1:0]       y_q;

  logic signed [ACCW-1:0] mac_sum, v_cur, v_leak, v_new, load_val;
  logic                   load;

  logic                   pend_q;
  logic [1:0]             pend_sel_q;
  logic [AW-1:0]          pend_addr_q;
  logic [ACCW-1:0]        pend_data_q;
  logic                   wr_en, wr_ok;
  logic [1:0]             wr_sel;
  logic [AW-1:0]          wr_addr;
  logic [ACCW-1:0]        wr_data;

  // ---------------- controller ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid)  state_d = ST_MAC;
      ST_MAC:  if (fin_last)  state_d = ST_OUT;
      ST_OUT:  if (out_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_OUT);
    cfg_busy  = (state_q != ST_IDLE);
  end

  assign accept   = in_valid && (state_q == ST_IDLE);
  assign issue    = (state_q == ST_MAC) && iss_q;
  assign fin      = prod_vld && (ti_q == IW'(N_IN - 1));
  assign fin_last = fin && (tj_q == JW'(N_OUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q    <= '0;
      mode_q <= 1'b0;
    end else if (accept) begin
      x_q    <= x_in;
      mode_q <= mode;
    end
  end

  // Issue counters (ii, jj) walk j outer / i inner; (ti, tj) tag the term
  // currently sitting in the product register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_q <= 1'b0;
      ii_q  <= '0;
      jj_q  <= '0;
      ti_q  <= '0;
      tj_q  <= '0;
    end else if (accept) begin
      iss_q <= 1'b1;
      ii_q  <= '0;
      jj_q  <= '0;
    end else if (issue) begin
      ti_q <= ii_q;
      tj_q <= jj_q;
      if (ii_q == IW'(N_IN - 1)) begin
        ii_q <= '0;
        if (jj_q == JW'(N_OUT - 1)) iss_q <= 1'b0;
        else                        jj_q  <= jj_q + 1'b1;
      end else begin
        ii_q <= ii_q + 1'b1;
      end
    end
  end

  // ---------------- datapath ----------------
  assign wk = AW'(int'(jj_q) * N_IN + int'(ii_q));
  assign jn = (tj_q == JW'(N_OUT - 1)) ? '0 : tj_q + 1'b1;

  // Each neuron's accumulator starts at its bias: bias 0 on accept, the next
  // bias on the cycle the previous neuron finishes.
  assign load     = accept || (fin && !fin_last);
  assign load_val = accept ? b_q[0] : b_q[jn];

  neuron_mac #(.XW(XW), .WW(WW), .ACCW(ACCW)) u_mac (
    .clk        (clk),
    .rst        (rst),
    .issue_i    (issue),
    .x_i        (x_q[ii_q]),
    .w_i        (w_q[wk]),
    .load_i     (load),
    .load_val_i (load_val),
    .prod_vld_o (prod_vld),
    .sum_o      (mac_sum)
  );

  always_comb begin
    v_cur  = v_q[tj_q];
    v_leak = ACCW'(sat_add(64'(v_cur), -64'(v_cur >>> LEAK), ACCW));
    v_new  = ACCW'(sat_add(64'(v_leak), 64'(mac_sum), ACCW));
    fire   = mode_q ? (v_new >= t_q[tj_q]) : (mac_sum >= t_q[tj_q]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q <= '0;
      for (int j = 0; j < N_OUT; j++) v_q[j] <= '0;
    end else begin
      // clear is only honoured in IDLE, where no finalize can happen, so the
      // two updates never collide; clear with accept zeroes v before use.
      if ((state_q == ST_IDLE) && clear)
        for (int j = 0; j < N_OUT; j++) v_q[j] <= '0;
      if (fin) begin
        y_q[tj_q] <= fire;
        if (mode_q) v_q[tj_q] <= fire ? '0 : v_new;
      end
    end
  end

  assign y_out = y_q;

  // ---------------- configuration ----------------
  // A write landing on the accept edge is parked and committed on the edge
  // the computation finishes, so the running computation sees old values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q      <= 1'b0;
      pend_sel_q  <= '0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
    end else if (accept) begin
      pend_q      <= cfg_we;
      pend_sel_q  <= cfg_sel;
      pend_addr_q <= cfg_addr;
      pend_data_q <= cfg_data;
    end else if (fin_last) begin
      pend_q <= 1'b0;
    end
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_sel  = cfg_sel;
    wr_addr = cfg_addr;
    wr_data = cfg_data;
    if (fin_last && pend_q) begin
      wr_en   = 1'b1;
      wr_sel  = pend_sel_q;
      wr_addr = pend_addr_q;
      wr_data = pend_data_q;
    end else if ((state_q == ST_IDLE) && cfg_we && !in_valid) begin
      wr_en = 1'b1;
    end
    case (wr_sel)
      CFG_W:   wr_ok = int'(wr_addr) < NT;
      CFG_B,
      CFG_T:   wr_ok = int'(wr_addr) < N_OUT;
      default: wr_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NT; k++)    w_q[k] <= '0;
      for (int j = 0; j < N_OUT; j++) b_q[j] <= '0;
      for (int j = 0; j < N_OUT; j++) t_q[j] <= '0;
    end else if (wr_en && wr_ok) begin
      case (wr_sel)
        CFG_W:   w_q[wr_addr]         <= wr_data[WW-1:0];
        CFG_B:   b_q[wr_addr[JW-1:0]] <= wr_data;
        CFG_T:   t_q[wr_addr[JW-1:0]] <= wr_data;
        default: ;
      endcase
    end
  end

endmodule
